// File: rtl/serial_rx_param.sv
// Parametrised serial receiver: mid-bit sampling, configurable parity/stop bits,
// false-start rejection, framing-error recovery and a valid/ready holding register.
module serial_rx_param #(
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 1,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 1,
   parameter int DROP_BAD     = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_data,
   input  logic                 i_ready,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] T_FULL    = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] T_HALF    = (CLKS_PER_BIT > 1) ? TW'(CLKS_PER_BIT / 2 - 1) : '0;
   localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
   localparam bit            KEEP_BAD  = (DROP_BAD == 0);
   localparam bit            HAS_PAR   = (PARITY_MODE != 0);
   localparam bit            ODD_PAR   = (PARITY_MODE == 1);

   // Valid/ready: a word transfers on any rising edge where o_valid=1 and i_ready=1;
   // o_data is stable while o_valid=1 and i_ready=0.

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t               state;
   state_t               state_next;

   logic [TW-1:0]        timer;
   logic [CW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 par_err_q;
   logic                 stop_err_q;

   logic                 tick;
   logic                 commit;
   logic                 par_bad;
   logic                 bad_frame;
   logic                 want_load;
   logic                 can_load;

   assign tick = (timer == '0);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (!i_data) begin
               state_next = (CLKS_PER_BIT == 1) ? S_DATA : S_START;
            end
         end
         S_START: begin
            if (tick) begin
               state_next = i_data ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tick && (bit_cnt == LAST_DATA)) begin
               state_next = HAS_PAR ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (tick) begin
               state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (tick && (bit_cnt == LAST_STOP)) begin
               // A low final stop bit may be a break; wait for the line to go idle.
               state_next = i_data ? S_IDLE : S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (i_data) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output/decode logic
   always_comb begin
      o_busy    = (state != S_IDLE);
      commit    = (state == S_STOP) && tick && (bit_cnt == LAST_STOP);
      par_bad   = ODD_PAR ? ~(^shift_reg ^ i_data) : (^shift_reg ^ i_data);
      bad_frame = par_err_q | stop_err_q | ~i_data;
      want_load = KEEP_BAD | ~bad_frame;
      can_load  = ~o_valid | i_ready;
   end

   // Bit timer, bit counter, shifter and per-frame error accumulators
   always_ff @(posedge clk) begin
      if (rst) begin
         timer      <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         par_err_q  <= 1'b0;
         stop_err_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!i_data) begin
                  timer      <= T_HALF;
                  bit_cnt    <= '0;
                  par_err_q  <= 1'b0;
                  stop_err_q <= 1'b0;
               end
            end
            S_START, S_DATA, S_PARITY, S_STOP: begin
               timer <= tick ? T_FULL : timer - 1'b1;
            end
            default: ;
         endcase

         if (tick) begin
            case (state)
               S_DATA: begin
                  shift_reg <= {i_data, shift_reg[DATA_BITS-1:1]};
                  bit_cnt   <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
               end
               S_PARITY: begin
                  par_err_q <= par_bad;
               end
               S_STOP: begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (!i_data) begin
                     stop_err_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Holding register and one-cycle status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_parity_err <= commit & par_err_q;
         o_frame_err  <= commit & (stop_err_q | ~i_data);
         o_overrun    <= commit & want_load & ~can_load;
         if (commit && want_load && can_load) begin
            o_data  <= shift_reg;
            o_valid <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_rx_param.sv
// Bench for serial_rx_param: three configurations driven from shared tasks,
// loaded words checked against per-instance expected queues.
module tb_serial_rx_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line_ab = 1'b1;
   logic       line_c = 1'b1;
   logic       ready_a = 1'b0;
   logic       ready_b = 1'b0;
   logic       ready_c = 1'b0;

   logic [7:0] data_a, data_b, data_c;
   logic       valid_a, valid_b, valid_c;
   logic       perr_a, perr_b, perr_c;
   logic       ferr_a, ferr_b, ferr_c;
   logic       ovr_a, ovr_b, ovr_c;
   logic       busy_a, busy_b, busy_c;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic [7:0] exp_c[$];

   int n_cmp = 0;
   int n_err = 0;
   int perr_cnt_a = 0, ferr_cnt_a = 0, ovr_cnt_a = 0;
   int perr_cnt_b = 0, ferr_cnt_b = 0, ovr_cnt_b = 0;
   int perr_cnt_c = 0, ferr_cnt_c = 0, ovr_cnt_c = 0;
   logic va_last = 1'b0, ra_last = 1'b0;
   logic vb_last = 1'b0, rb_last = 1'b0;
   logic vc_last = 1'b0, rc_last = 1'b0;

   // clock / reset
   always #5 clk = ~clk;

   serial_rx_param dut_a (
      .clk(clk), .rst(rst), .i_data(line_ab), .i_ready(ready_a),
      .o_data(data_a), .o_valid(valid_a), .o_parity_err(perr_a),
      .o_frame_err(ferr_a), .o_overrun(ovr_a), .o_busy(busy_a)
   );

   serial_rx_param #(.DROP_BAD(1)) dut_b (
      .clk(clk), .rst(rst), .i_data(line_ab), .i_ready(ready_b),
      .o_data(data_b), .o_valid(valid_b), .o_parity_err(perr_b),
      .o_frame_err(ferr_b), .o_overrun(ovr_b), .o_busy(busy_b)
   );

   serial_rx_param #(.CLKS_PER_BIT(4), .PARITY_MODE(2)) dut_c (
      .clk(clk), .rst(rst), .i_data(line_c), .i_ready(ready_c),
      .o_data(data_c), .o_valid(valid_c), .o_parity_err(perr_c),
      .o_frame_err(ferr_c), .o_overrun(ovr_c), .o_busy(busy_c)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic odd_par(input logic [7:0] d);
      return ~(^d);
   endfunction

   // driver tasks
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #2;
   endtask

   task automatic drive(input int sel, input logic b, input int cpb);
      if (sel == 0) line_ab = b;
      else line_c = b;
      repeat (cpb) sync();
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d, input logic par,
                             input logic stp, input int cpb, input bit rdy_commit);
      drive(sel, 1'b0, cpb);
      for (int i = 0; i < 8; i++) drive(sel, d[i], cpb);
      drive(sel, par, cpb);
      if (rdy_commit) begin
         ready_a = 1'b1;
         ready_b = 1'b1;
      end
      drive(sel, stp, cpb);
      ready_a = 1'b0;
      ready_b = 1'b0;
      if (sel == 0) line_ab = 1'b1;
      else line_c = 1'b1;
   endtask

   task automatic consume_ab();
      ready_a = 1'b1;
      ready_b = 1'b1;
      sync();
      ready_a = 1'b0;
      ready_b = 1'b0;
   endtask

   // scoreboard monitors: a new word is present when o_valid rises or reloads after a transfer
   always @(negedge clk) begin
      if (valid_a && (!va_last || ra_last)) begin
         if (exp_a.size() == 0) check("a_word_expected", 32'(exp_a.size()), 32'd1);
         else check("a_data", 32'(data_a), 32'(exp_a.pop_front()));
      end
      va_last = valid_a;
      ra_last = ready_a;
      perr_cnt_a += int'(perr_a);
      ferr_cnt_a += int'(ferr_a);
      ovr_cnt_a  += int'(ovr_a);
   end

   always @(negedge clk) begin
      if (valid_b && (!vb_last || rb_last)) begin
         if (exp_b.size() == 0) check("b_word_expected", 32'(exp_b.size()), 32'd1);
         else check("b_data", 32'(data_b), 32'(exp_b.pop_front()));
      end
      vb_last = valid_b;
      rb_last = ready_b;
      perr_cnt_b += int'(perr_b);
      ferr_cnt_b += int'(ferr_b);
      ovr_cnt_b  += int'(ovr_b);
   end

   always @(negedge clk) begin
      if (valid_c && (!vc_last || rc_last)) begin
         if (exp_c.size() == 0) check("c_word_expected", 32'(exp_c.size()), 32'd1);
         else check("c_data", 32'(data_c), 32'(exp_c.pop_front()));
      end
      vc_last = valid_c;
      rc_last = ready_c;
      perr_cnt_c += int'(perr_c);
      ferr_cnt_c += int'(ferr_c);
      ovr_cnt_c  += int'(ovr_c);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      settle();
      check("rst_valid_a", 32'(valid_a), 32'd0);
      check("rst_data_a", 32'(data_a), 32'd0);
      check("rst_busy_a", 32'(busy_a), 32'd0);
      check("rst_pulses_a", 32'({perr_a, ferr_a, ovr_a}), 32'd0);
      check("rst_busy_c", 32'(busy_c), 32'd0);

      // 1: clean frame, then a single-cycle transfer
      sync();
      exp_a.push_back(8'h55);
      exp_b.push_back(8'h55);
      send_frame(0, 8'h55, 1'b1, 1'b1, 1, 1'b0);
      settle();
      check("t1_valid_a", 32'(valid_a), 32'd1);
      check("t1_pulses_a", 32'(perr_cnt_a + ferr_cnt_a + ovr_cnt_a), 32'd0);
      sync();
      consume_ab();
      settle();
      check("t1_consumed_a", 32'(valid_a), 32'd0);
      check("t1_consumed_b", 32'(valid_b), 32'd0);

      // 2: parity error, kept by a, dropped by b
      sync();
      exp_a.push_back(8'h01);
      send_frame(0, 8'h01, ~odd_par(8'h01), 1'b1, 1, 1'b0);
      settle();
      check("t2_perr_a", 32'(perr_cnt_a), 32'd1);
      check("t2_perr_b", 32'(perr_cnt_b), 32'd1);
      check("t2_valid_a", 32'(valid_a), 32'd1);
      check("t2_valid_b", 32'(valid_b), 32'd0);
      sync();
      consume_ab();

      // 3: framing error followed by a 5-cycle break
      exp_a.push_back(8'hAA);
      send_frame(0, 8'hAA, odd_par(8'hAA), 1'b0, 1, 1'b0);
      line_ab = 1'b0;
      repeat (5) sync();
      settle();
      check("t3_busy_break", 32'(busy_a), 32'd1);
      sync();
      line_ab = 1'b1;
      sync();
      settle();
      check("t3_busy_idle", 32'(busy_a), 32'd0);
      repeat (12) sync();
      check("t3_ferr_a", 32'(ferr_cnt_a), 32'd1);
      check("t3_ferr_b", 32'(ferr_cnt_b), 32'd1);
      check("t3_valid_b", 32'(valid_b), 32'd0);
      check("t3_busy_after", 32'(busy_a), 32'd0);
      consume_ab();

      // 4a: overrun with the consumer stalled
      exp_a.push_back(8'h55);
      exp_b.push_back(8'h55);
      send_frame(0, 8'h55, odd_par(8'h55), 1'b1, 1, 1'b0);
      send_frame(0, 8'h33, odd_par(8'h33), 1'b1, 1, 1'b0);
      settle();
      check("t4_ovr_a", 32'(ovr_cnt_a), 32'd1);
      check("t4_ovr_b", 32'(ovr_cnt_b), 32'd1);
      check("t4_keep_a", 32'(data_a), 32'h55);
      sync();
      consume_ab();

      // 4b: consumer ready on the commit edge, new word replaces old
      exp_a.push_back(8'h55);
      exp_b.push_back(8'h55);
      send_frame(0, 8'h55, odd_par(8'h55), 1'b1, 1, 1'b0);
      exp_a.push_back(8'h33);
      exp_b.push_back(8'h33);
      send_frame(0, 8'h33, odd_par(8'h33), 1'b1, 1, 1'b1);
      settle();
      check("t4b_ovr_a", 32'(ovr_cnt_a), 32'd1);
      check("t4b_data_a", 32'(data_a), 32'h33);
      check("t4b_valid_a", 32'(valid_a), 32'd1);
      sync();
      consume_ab();

      // 5: glitch rejection and a 4-clock-per-bit even-parity frame
      line_c = 1'b0;
      sync();
      line_c = 1'b1;
      settle();
      check("t5_glitch_busy", 32'(busy_c), 32'd1);
      repeat (4) sync();
      settle();
      check("t5_glitch_idle", 32'(busy_c), 32'd0);
      check("t5_glitch_valid", 32'(valid_c), 32'd0);
      sync();
      exp_c.push_back(8'hAA);
      send_frame(1, 8'hAA, ^8'hAA, 1'b1, 4, 1'b0);
      settle();
      check("t5_valid_c", 32'(valid_c), 32'd1);
      check("t5_errs_c", 32'(perr_cnt_c + ferr_cnt_c + ovr_cnt_c), 32'd0);

      // 6: reset in the middle of a frame while a word is pending
      sync();
      exp_a.push_back(8'h3C);
      exp_b.push_back(8'h3C);
      send_frame(0, 8'h3C, odd_par(8'h3C), 1'b1, 1, 1'b0);
      drive(0, 1'b0, 1);
      for (int i = 0; i < 4; i++) drive(0, i[0], 1);
      line_ab = 1'b1;
      rst = 1'b1;
      sync();
      rst = 1'b0;
      settle();
      check("t6_busy_a", 32'(busy_a), 32'd0);
      check("t6_valid_a", 32'(valid_a), 32'd0);
      check("t6_valid_b", 32'(valid_b), 32'd0);
      sync();
      exp_a.push_back(8'h5A);
      exp_b.push_back(8'h5A);
      send_frame(0, 8'h5A, odd_par(8'h5A), 1'b1, 1, 1'b0);
      settle();
      check("t6_data_a", 32'(data_a), 32'h5A);
      check("t6_perr_a", 32'(perr_cnt_a), 32'd1);
      sync();
      consume_ab();
      repeat (4) sync();

      // final report
      check("end_q_a", 32'(exp_a.size()), 32'd0);
      check("end_q_b", 32'(exp_b.size()), 32'd0);
      check("end_q_c", 32'(exp_c.size()), 32'd0);
      check("end_ferr_a", 32'(ferr_cnt_a), 32'd1);
      check("end_ovr_b", 32'(ovr_cnt_b), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_rx_param.md
Name: serial_rx_param

Overview:
Parametrised asynchronous-style serial receiver, the successor to the fixed 8-bit odd-parity receiver. Configurable data width, parity mode (none/odd/even), stop-bit count and clocks-per-bit with mid-bit sampling. Adds false-start rejection, framing-error detection with line-idle recovery, and a valid/ready output holding register with overrun reporting. Sits between the serial pin (already synchronised) and the byte consumer.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first; legal 5..16
PARITY_MODE, 1, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal 1 or 2
CLKS_PER_BIT, 1, clock cycles per serial bit; legal >= 1
DROP_BAD, 0, 1 = frames with parity/framing error are not loaded into the output register

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
i_data  in  1  serial line, idle high
i_ready  in  1  consumer accepts o_data when o_valid=1
o_data  out  DATA_BITS  received word (holding register)
o_valid  out  1  o_data holds an unconsumed word
o_parity_err  out  1  one-cycle pulse: parity mismatch on the just-finished frame
o_frame_err  out  1  one-cycle pulse: a stop bit sampled 0
o_overrun  out  1  one-cycle pulse: completed frame lost because holding register full
o_busy  out  1  1 whenever FSM is not IDLE

Behaviour:
- Reset (rst=1 at edge, any state): FSM to IDLE; o_data=0, o_valid=0, all pulses 0, o_busy=0; partial frame discarded.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Bit timer of width max(1,clog2(CLKS_PER_BIT)); bit counter sized for DATA_BITS.
- IDLE: i_data=0 at an edge = start detect. If CLKS_PER_BIT=1, go to DATA with timer=0. Otherwise go to START with timer=CLKS_PER_BIT/2-1.
- START: decrement timer; at timer=0 resample. i_data=0 -> DATA, timer=CLKS_PER_BIT-1. i_data=1 -> IDLE (false start, no flags).
- DATA/PARITY/STOP: each sample is taken on the edge where timer=0, then timer reloads CLKS_PER_BIT-1. With CLKS_PER_BIT=1 this means one sample per cycle, and data bit 0 is sampled on the cycle immediately after the start bit.
- DATA: shift LSB first. After DATA_BITS samples -> PARITY if PARITY_MODE!=0, else STOP.
- PARITY: parity error = (XOR of data bits ^ parity bit) != 1 for odd, != 0 for even.
- STOP: sample STOP_BITS bits; any 0 sets the frame error.
- Commit happens on the edge that samples the final stop bit. Flags, o_data and o_valid are visible the following cycle.
  - Error pulses assert for exactly one cycle regardless of DROP_BAD.
  - Load the holding register if (DROP_BAD=0 or frame clean) and (o_valid=0 or i_ready=1).
  - If a load is wanted but o_valid=1 and i_ready=0: keep the old word, discard the new one, pulse o_overrun.
- After commit: clean stop -> IDLE. If the last stop bit was 0 -> WAIT_IDLE, held until i_data=1 is sampled, then IDLE. A break (line held low) is never taken as a new start.
- Handshake: o_valid=1 and i_ready=1 at an edge clears o_valid, unless a commit loads a new word on the same edge, in which case o_valid stays 1 with the new data.
- o_busy is combinational from the state (state != IDLE).

Test Plan:
1. Defaults, i_ready=0. Frame: start 0, 0x55 LSB first, parity 1, stop 1 -> cycle after stop sample: o_valid=1, o_data=0x55, no error pulses. Then i_ready=1 for one cycle -> o_valid=0.
2. Defaults. Frame 0x01 with parity 1 -> o_parity_err pulses once, o_valid=1, o_data=0x01. Rebuild with DROP_BAD=1, same frame -> pulse occurs, o_valid stays 0.
3. Defaults. Frame 0xAA with stop bit 0, line held low 5 cycles, then high -> o_frame_err pulses once, o_busy=1 until the first high sample, no spurious second frame.
4. Overrun. Two back-to-back frames 0x55 then 0x33, i_ready=0 -> o_data stays 0x55, o_overrun pulses at the second commit. Repeat with i_ready=1 on the second commit cycle -> o_data=0x33, no overrun.
5. CLKS_PER_BIT=4, PARITY_MODE=2. A 1-cycle low glitch -> returns to IDLE, nothing received. Then a full frame 0xAA with parity 0, 4 cycles per bit -> o_data=0xAA, no errors.
6. Reset mid-frame: assert rst after data bit 3 -> next cycle o_busy=0, o_valid=0. A following full frame 0x5A with parity 1 is received correctly.
